// File: rtl/mem_arbiter.sv
// Shares the single-ported main memory between fetch and load/store.
// Define MEM_ARB_STARVE_GUARD_EN to bound how long fetch can be starved.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clockg,
  input  logic          rst,
  input  logic          halt_sys,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_write_en,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_write_data,
  input  logic [DW-1:0] mem_data_out
);

  logic open;
  logic starve;

  assign open = !rst && !halt_sys;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] cnt;

  assign starve = f_req && (cnt >= 4'(STARVE_LIMIT));

  always_ff @(posedge clockg or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!halt_sys) begin
      if (f_gnt || !f_req)
        cnt <= '0;
      else if (d_gnt && cnt != 4'hF)
        cnt <= cnt + 4'd1;
    end
  end
`else
  // A zero limit would mean fetch always wins; legal limits never do.
  assign starve = f_req && (STARVE_LIMIT == 0);
`endif

  always_comb begin
    d_gnt = open && d_req && !starve;
    f_gnt = open && f_req && !d_gnt;
  end

  always_comb begin
    mem_write_en   = 1'b0;
    mem_address    = f_addr;
    mem_write_data = '0;
    if (d_gnt) begin
      mem_write_en   = d_we;
      mem_address    = d_addr;
      mem_write_data = d_wdata;
    end
  end

  always_ff @(posedge clockg or posedge rst) begin
    if (rst) begin
      f_rvalid <= 1'b0;
      f_rdata  <= '0;
    end else begin
      f_rvalid <= f_gnt;
      if (f_gnt)
        f_rdata <= mem_data_out;
    end
  end

  always_ff @(posedge clockg or posedge rst) begin
    if (rst) begin
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
    end else begin
      d_rvalid <= d_gnt && !d_we;
      if (d_gnt && !d_we)
        d_rdata <= mem_data_out;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grant/mux table plus
// multi-cycle sequences against a behavioural memory.
module tb_mem_arbiter;

  logic        clockg = 1'b0;
  logic        rst;
  logic        halt_sys;
  logic        f_req;
  logic [15:0] f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic [15:0] f_rdata;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [15:0] d_rdata;
  logic        mem_write_en;
  logic [15:0] mem_address;
  logic [15:0] mem_write_data;
  logic [15:0] mem_data_out;

  bit [15:0] mem [0:32767];

  int nvec = 0;
  int nerr = 0;

  mem_arbiter #(.STARVE_LIMIT(4), .AW(16), .DW(16)) dut (
    .clockg(clockg),
    .rst(rst),
    .halt_sys(halt_sys),
    .f_req(f_req),
    .f_addr(f_addr),
    .f_gnt(f_gnt),
    .f_rvalid(f_rvalid),
    .f_rdata(f_rdata),
    .d_req(d_req),
    .d_we(d_we),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_gnt(d_gnt),
    .d_rvalid(d_rvalid),
    .d_rdata(d_rdata),
    .mem_write_en(mem_write_en),
    .mem_address(mem_address),
    .mem_write_data(mem_write_data),
    .mem_data_out(mem_data_out)
  );

  always #5 clockg = ~clockg;

  assign mem_data_out = mem[mem_address[15:1]];

  always @(posedge clockg)
    if (mem_write_en)
      mem[mem_address[15:1]] <= mem_write_data;

  typedef struct {
    logic        h;
    logic        fr;
    logic [15:0] fa;
    logic        dr;
    logic        dw;
    logic [15:0] da;
    logic [15:0] dd;
    logic        e_fg;
    logic        e_dg;
    logic        e_we;
    logic [15:0] e_ma;
    logic [15:0] e_md;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic h, input logic fr,
                       input logic [15:0] fa, input logic dr,
                       input logic dw, input logic [15:0] da,
                       input logic [15:0] dd);
    halt_sys = h;
    f_req    = fr;
    f_addr   = fa;
    d_req    = dr;
    d_we     = dw;
    d_addr   = da;
    d_wdata  = dd;
  endtask

  task automatic idle();
    drive(0, 0, 16'h0, 0, 0, 16'h0, 16'h0);
  endtask

  initial begin
    tbl[0] = '{0,1,16'h0100,0,0,16'h0200,16'h1111,
               1,0,0,16'h0100,16'h0000};
    tbl[1] = '{0,0,16'h0102,1,0,16'h0202,16'h2222,
               0,1,0,16'h0202,16'h2222};
    tbl[2] = '{0,1,16'h0104,1,1,16'h00F0,16'h3333,
               0,1,1,16'h00F0,16'h3333};
    tbl[3] = '{1,1,16'h0106,1,1,16'h00F2,16'h4444,
               0,0,0,16'h0106,16'h0000};
    tbl[4] = '{0,0,16'h0108,0,1,16'h00F4,16'h5555,
               0,0,0,16'h0108,16'h0000};
    tbl[5] = '{0,1,16'hFFFE,0,0,16'h0000,16'h0000,
               1,0,0,16'hFFFE,16'h0000};

    // reset with every request asserted
    rst = 1'b1;
    drive(0, 1, 16'h0010, 1, 1, 16'h0020, 16'h1234);
    #2;
    chk("rst_f_gnt", f_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_we", mem_write_en, 0);
    chk("rst_f_rvalid", f_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_f_rdata", f_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    @(negedge clockg);
    chk("rst_hold_f_rvalid", f_rvalid, 0);
    chk("rst_hold_d_rdata", d_rdata, 0);
    rst = 1'b0;
    idle();

    for (int i = 0; i < 6; i++) begin
      @(negedge clockg);
      drive(tbl[i].h, tbl[i].fr, tbl[i].fa, tbl[i].dr,
            tbl[i].dw, tbl[i].da, tbl[i].dd);
      #1;
      chk($sformatf("v%0d_f_gnt", i), f_gnt, tbl[i].e_fg);
      chk($sformatf("v%0d_d_gnt", i), d_gnt, tbl[i].e_dg);
      chk($sformatf("v%0d_we", i), mem_write_en, tbl[i].e_we);
      chk($sformatf("v%0d_addr", i), mem_address, tbl[i].e_ma);
      chk($sformatf("v%0d_wdata", i), mem_write_data, tbl[i].e_md);
    end

    // preload through the data port
    @(negedge clockg);
    drive(0, 0, 16'h0, 1, 1, 16'h0010, 16'hBEEF);
    #1 chk("pre_we", mem_write_en, 1);
    @(negedge clockg);
    chk("wr_no_rvalid", d_rvalid, 0);
    drive(0, 0, 16'h0, 1, 1, 16'h0002, 16'hAAAA);
    @(negedge clockg);
    drive(0, 0, 16'h0, 1, 1, 16'h0004, 16'h5555);
    @(negedge clockg);
    idle();

    // fetch read
    @(negedge clockg);
    drive(0, 1, 16'h0010, 0, 0, 16'h0, 16'h0);
    #1;
    chk("fr_f_gnt", f_gnt, 1);
    chk("fr_addr", mem_address, 16'h0010);
    @(negedge clockg);
    idle();
    chk("fr_rvalid", f_rvalid, 1);
    chk("fr_rdata", f_rdata, 16'hBEEF);
    chk("fr_d_rvalid", d_rvalid, 0);
    @(negedge clockg);
    chk("fr_rvalid_drop", f_rvalid, 0);
    chk("fr_rdata_hold", f_rdata, 16'hBEEF);

    // contention: data write beats fetch
    drive(0, 1, 16'h0000, 1, 1, 16'h0020, 16'h1234);
    #1;
    chk("ct_d_gnt", d_gnt, 1);
    chk("ct_f_gnt", f_gnt, 0);
    chk("ct_we", mem_write_en, 1);
    chk("ct_addr", mem_address, 16'h0020);
    @(negedge clockg);
    d_req = 0;
    #1;
    chk("ct_f_gnt_next", f_gnt, 1);
    chk("ct_f_addr", mem_address, 16'h0000);
    @(negedge clockg);
    drive(0, 0, 16'h0, 1, 0, 16'h0020, 16'h0);
    @(negedge clockg);
    idle();
    chk("ct_rd_rvalid", d_rvalid, 1);
    chk("ct_rd_data", d_rdata, 16'h1234);

    // back-to-back data reads
    @(negedge clockg);
    drive(0, 0, 16'h0, 1, 0, 16'h0002, 16'h0);
    @(negedge clockg);
    d_addr = 16'h0004;
    chk("pp_rvalid0", d_rvalid, 1);
    chk("pp_rdata0", d_rdata, 16'hAAAA);
    @(negedge clockg);
    idle();
    chk("pp_rvalid1", d_rvalid, 1);
    chk("pp_rdata1", d_rdata, 16'h5555);
    @(negedge clockg);
    chk("pp_rvalid_drop", d_rvalid, 0);

    // halt after an accepted read
    drive(0, 0, 16'h0, 1, 0, 16'h0010, 16'h0);
    @(negedge clockg);
    drive(1, 1, 16'h0006, 1, 1, 16'h0030, 16'h9999);
    #1;
    chk("ht_rvalid", d_rvalid, 1);
    chk("ht_rdata", d_rdata, 16'hBEEF);
    chk("ht_d_gnt", d_gnt, 0);
    chk("ht_f_gnt", f_gnt, 0);
    chk("ht_we", mem_write_en, 0);
    @(negedge clockg);
    chk("ht_rvalid_drop", d_rvalid, 0);
    chk("ht_d_gnt2", d_gnt, 0);
    chk("ht_we2", mem_write_en, 0);
    halt_sys = 0;
    #1 chk("ht_release", d_gnt, 1);
    d_req = 0;
    f_req = 0;
    @(negedge clockg);
    idle();

    // starvation: data reads held with fetch waiting
    @(negedge clockg);
    drive(0, 1, 16'h0000, 1, 0, 16'h0002, 16'h0);
    for (int k = 1; k <= 6; k++) begin
      logic ef;
`ifdef MEM_ARB_STARVE_GUARD_EN
      ef = (k == 5);
`else
      ef = 1'b0;
`endif
      #1;
      chk($sformatf("sv%0d_f_gnt", k), f_gnt, ef);
      chk($sformatf("sv%0d_d_gnt", k), d_gnt, !ef);
      @(negedge clockg);
    end
    d_req = 0;
    #1 chk("sv_f_after", f_gnt, 1);
    @(negedge clockg);
    idle();

    // reset mid-flight drops the pending response
    drive(0, 0, 16'h0, 1, 0, 16'h0004, 16'h0);
    @(negedge clockg);
    idle();
    chk("mr_rvalid_pre", d_rvalid, 1);
    rst = 1'b1;
    #1;
    chk("mr_rvalid", d_rvalid, 0);
    chk("mr_rdata", d_rdata, 0);
    @(negedge clockg);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
